// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-scheduling engine.
// Build option: define RC4_KSA_INIT_EN to let the engine fill S[k] = k itself
// before the shuffle; without it the S-array must be loaded beforehand.
package rc4_pkg;

    localparam int KEY_BYTE_W = 8;

    // Engine states; fixed encodings keep the debug view stable across builds.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
`ifdef RC4_KSA_INIT_EN
        S_INIT   = 4'd1,
`else
`endif
        S_RD_I   = 4'd2,
        S_WAIT_I = 4'd3,
        S_CAP_I  = 4'd4,
        S_WAIT_J = 4'd5,
        S_CAP_J  = 4'd6,
        S_WR_J   = 4'd7,
        S_WR_I   = 4'd8,
        S_NEXT   = 4'd9,
        S_DONE   = 4'd10
    } state_t;

endpackage

// File: rtl/rc4_key_sel.sv
// Key byte selector for the RC4 KSA engine: owns the wrapping key-index
// counter (i mod KEY_BYTES without a divider) and picks that byte from the
// captured key, byte 0 being the most significant byte.
module rc4_key_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_clear,
    input  logic                            i_advance,
    input  logic [KEY_BYTE_W*KEY_BYTES-1:0] i_key,
    output logic [KEY_BYTE_W-1:0]           o_key_byte
);

    localparam int IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_BYTES - 1);

    logic [IDX_W-1:0] r_idx;

    // Key index: cleared at run start, wraps after the last key byte.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_idx <= '0;
        end else if (i_clear) begin
            r_idx <= '0;
        end else if (i_advance) begin
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    // Byte multiplexer: byte b sits at the top end of the key word for b = 0.
    always_comb begin
        o_key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (r_idx == IDX_W'(b)) begin
                o_key_byte = i_key[KEY_BYTE_W*(KEY_BYTES-1-b) +: KEY_BYTE_W];
            end
        end
    end

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving an external S-array with a one-cycle
// synchronous read port: an address registered in RD_I/CAP_I returns q two
// cycles after that state (in CAP_I/CAP_J). Each i iteration is 8 cycles.
// Build option: RC4_KSA_INIT_EN adds the INIT state (S[k] = k, N cycles).
// Handshake: start is sampled only in IDLE; finish pulses one cycle in DONE;
// abort returns any active run to IDLE on the next edge without finish.
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [KEY_BYTE_W*KEY_BYTES-1:0] secret_key,
    input  logic [DATA_W-1:0]               q,
    output logic [ADDR_W-1:0]               address,
    output logic [DATA_W-1:0]               data,
    output logic                            wren,
    output logic                            busy,
    output logic                            finish,
    output logic [3:0]                      o_dbg_state
);

    localparam logic [ADDR_W-1:0] I_LAST = '1;

    state_t                          r_state;
    logic [ADDR_W-1:0]               r_i;
    logic [ADDR_W-1:0]               r_j;
    logic [DATA_W-1:0]               r_si;
    logic [DATA_W-1:0]               r_sj;
    logic [KEY_BYTE_W*KEY_BYTES-1:0] r_key;
    logic [ADDR_W-1:0]               r_address;
    logic [DATA_W-1:0]               r_data;
    logic                            r_wren;
    logic                            r_busy;
    logic                            r_finish;

    logic                            w_accept;
    logic [KEY_BYTE_W-1:0]           w_key_byte;
    logic [ADDR_W-1:0]               w_j_next;
    logic [ADDR_W-1:0]               w_i_inc;

    assign w_accept = (r_state == S_IDLE) && start && !abort;
    assign w_j_next = r_j + ADDR_W'(q) + ADDR_W'(w_key_byte);
    assign w_i_inc  = r_i + 1'b1;

    rc4_key_sel #(
        .KEY_BYTES (KEY_BYTES)
    ) u_key_sel (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_clear    (w_accept),
        .i_advance  (r_state == S_CAP_I),
        .i_key      (r_key),
        .o_key_byte (w_key_byte)
    );

    // Main FSM with registered S-array port, busy and finish.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_i       <= '0;
            r_j       <= '0;
            r_si      <= '0;
            r_sj      <= '0;
            r_key     <= '0;
            r_address <= '0;
            r_data    <= '0;
            r_wren    <= 1'b0;
            r_busy    <= 1'b0;
            r_finish  <= 1'b0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_state  <= S_IDLE;
            r_wren   <= 1'b0;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_key  <= secret_key;
                        r_i    <= '0;
                        r_j    <= '0;
                        r_busy <= 1'b1;
`ifdef RC4_KSA_INIT_EN
                        r_state   <= S_INIT;
                        r_address <= '0;
                        r_data    <= '0;
                        r_wren    <= 1'b1;
`else
                        r_state   <= S_RD_I;
`endif
                    end
                end
`ifdef RC4_KSA_INIT_EN
                S_INIT: begin
                    if (r_i == I_LAST) begin
                        r_i     <= '0;
                        r_wren  <= 1'b0;
                        r_state <= S_RD_I;
                    end else begin
                        r_i       <= w_i_inc;
                        r_address <= w_i_inc;
                        r_data    <= DATA_W'(w_i_inc);
                    end
                end
`else
`endif
                S_RD_I: begin
                    r_address <= r_i;
                    r_state   <= S_WAIT_I;
                end
                S_WAIT_I: r_state <= S_CAP_I;
                S_CAP_I: begin
                    r_si      <= q;
                    r_j       <= w_j_next;
                    r_address <= w_j_next;
                    r_state   <= S_WAIT_J;
                end
                S_WAIT_J: r_state <= S_CAP_J;
                S_CAP_J: begin
                    // S[j] <= si is presented during WR_J.
                    r_sj      <= q;
                    r_address <= r_j;
                    r_data    <= r_si;
                    r_wren    <= 1'b1;
                    r_state   <= S_WR_J;
                end
                S_WR_J: begin
                    // S[i] <= sj; when i == j, sj equals si so the entry holds.
                    r_address <= r_i;
                    r_data    <= r_sj;
                    r_wren    <= 1'b1;
                    r_state   <= S_WR_I;
                end
                S_WR_I: begin
                    r_wren  <= 1'b0;
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_i == I_LAST) begin
                        r_finish <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_i     <= w_i_inc;
                        r_state <= S_RD_I;
                    end
                end
                S_DONE: begin
                    r_finish <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_wren   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_finish <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign address     = r_address;
    assign data        = r_data;
    assign wren        = r_wren;
    assign busy        = r_busy;
    assign finish      = r_finish;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: a small instance (N=4, 1-byte key) and a default
// instance (N=256, 3-byte key), each with its own S-array memory model.
// Build option RC4_KSA_INIT_EN is honoured through OFF_S / OFF_D.
module tb_rc4_ksa_engine;
    import rc4_pkg::*;

    localparam int SN = 4;
    localparam int DN = 256;
`ifdef RC4_KSA_INIT_EN
    localparam int OFF_S = SN;
    localparam int OFF_D = DN;
    localparam bit LOAD_RAND = 1'b1;
`else
    localparam int OFF_S = 0;
    localparam int OFF_D = 0;
    localparam bit LOAD_RAND = 1'b0;
`endif

    // ---------------- clock / counters ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int test_cnt  = 0;
    int fail_cnt  = 0;
    int s_fin_cnt = 0;
    int d_fin_cnt = 0;

    // ---------------- small DUT ----------------
    logic       s_rst_n, s_start, s_abort, s_load;
    logic [7:0] s_key, s_q, s_data;
    logic [1:0] s_addr;
    logic       s_wren, s_busy, s_finish;
    logic [3:0] s_dbg;
    logic [7:0] s_mem [SN];
    logic [1:0] s_wa_q [$];
    logic [7:0] s_wd_q [$];

    rc4_ksa_engine #(.KEY_BYTES(1), .ADDR_W(2), .DATA_W(8)) u_small (
        .clk(clk), .reset_n(s_rst_n), .start(s_start), .abort(s_abort),
        .secret_key(s_key), .q(s_q), .address(s_addr), .data(s_data),
        .wren(s_wren), .busy(s_busy), .finish(s_finish), .o_dbg_state(s_dbg)
    );

    always @(posedge clk) begin
        if (s_load) begin
            for (int k = 0; k < SN; k++) s_mem[k] <= LOAD_RAND ? 8'($urandom) : 8'(k);
        end else if (s_wren) begin
            s_mem[s_addr] <= s_data;
            s_wa_q.push_back(s_addr);
            s_wd_q.push_back(s_data);
        end
        s_q <= s_mem[s_addr];
    end

    // ---------------- default DUT ----------------
    logic        d_rst_n, d_start, d_abort, d_load;
    logic [23:0] d_key;
    logic [7:0]  d_q, d_data, d_addr;
    logic        d_wren, d_busy, d_finish;
    logic [3:0]  d_dbg;
    logic [7:0]  d_mem [DN];

    rc4_ksa_engine u_def (
        .clk(clk), .reset_n(d_rst_n), .start(d_start), .abort(d_abort),
        .secret_key(d_key), .q(d_q), .address(d_addr), .data(d_data),
        .wren(d_wren), .busy(d_busy), .finish(d_finish), .o_dbg_state(d_dbg)
    );

    always @(posedge clk) begin
        if (d_load) begin
            for (int k = 0; k < DN; k++) d_mem[k] <= LOAD_RAND ? 8'($urandom) : 8'(k);
        end else if (d_wren) begin
            d_mem[d_addr] <= d_data;
        end
        d_q <= d_mem[d_addr];
    end

    // ---------------- reference model / scoreboard ----------------
    int         ref_s [DN];
    logic [7:0] exp_q [$];

    task automatic ref_ksa(input logic [23:0] key, input int kb, input int n);
        int j, t, kbyte, kk;
        kk = int'(key);
        for (int k = 0; k < n; k++) ref_s[k] = k;
        j = 0;
        for (int i = 0; i < n; i++) begin
            kbyte = (kk >> (8 * (kb - 1 - (i % kb)))) & 255;
            j = (j + ref_s[i] + kbyte) % n;
            t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
        end
        for (int k = 0; k < n; k++) exp_q.push_back(8'(ref_s[k]));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (s_finish === 1'b1) s_fin_cnt++;
        if (d_finish === 1'b1) d_fin_cnt++;
    endtask

    task automatic run_small(input logic [7:0] key, input string tag);
        int n, fc, bad;
        s_load = 1'b1; tick(); s_load = 1'b0;
        s_wa_q.delete(); s_wd_q.delete();
        fc = s_fin_cnt;
        s_key = key; s_start = 1'b1;
        tick();                       // accepting edge (edge 0)
        s_start = 1'b0; s_key = 8'($urandom);
        n = 0; bad = 0;
        while (s_finish !== 1'b1 && n < 100) begin
            if (s_busy !== 1'b1) bad++;
            tick(); n++;
        end
        check({tag, " finish cycle"}, (n < 100) ? n + 1 : -1, OFF_S + 8 * SN + 1);
        check({tag, " busy in run"}, bad, 0);
        tick();
        check({tag, " finish width"}, s_finish, 1'b0);
        check({tag, " idle busy"}, s_busy, 1'b0);
        check({tag, " finish count"}, s_fin_cnt - fc, 1);
        check({tag, " write count"}, s_wa_q.size(), OFF_S + 2 * SN);
        ref_ksa({16'h0, key}, 1, SN);
        for (int k = 0; k < SN; k++) check($sformatf("%s S[%0d]", tag, k), s_mem[k], exp_q.pop_front());
    endtask

    task automatic run_def(input logic [23:0] key, input string tag);
        int n, fc, bad;
        d_load = 1'b1; tick(); d_load = 1'b0;
        fc = d_fin_cnt;
        d_key = key; d_start = 1'b1;
        tick();
        d_start = 1'b0;
        n = 0; bad = 0;
        while (d_finish !== 1'b1 && n < 3000) begin
            if (d_busy !== 1'b1) bad++;
            // stray start pulses and key changes while busy must be ignored
            d_start = ((n % 97) == 5);
            d_key   = 24'($urandom);
            tick(); n++;
        end
        d_start = 1'b0;
        check({tag, " finish cycle"}, (n < 3000) ? n + 1 : -1, OFF_D + 8 * DN + 1);
        check({tag, " busy in run"}, bad, 0);
        tick();
        check({tag, " finish width"}, d_finish, 1'b0);
        check({tag, " finish count"}, d_fin_cnt - fc, 1);
        ref_ksa(key, 3, DN);
        bad = 0;
        for (int k = 0; k < DN; k++) begin
            if (k < 4) check($sformatf("%s S[%0d]", tag, k), d_mem[k], exp_q[0]);
            else if (d_mem[k] !== exp_q[0]) bad++;
            void'(exp_q.pop_front());
        end
        check({tag, " S mismatches"}, bad, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int fc;
        s_rst_n = 1'b0; s_start = 1'b0; s_abort = 1'b0; s_load = 1'b0; s_key = '0;
        d_rst_n = 1'b0; d_start = 1'b0; d_abort = 1'b0; d_load = 1'b0; d_key = '0;
        repeat (3) tick();

        // reset state
        check("rst address", s_addr, 0);
        check("rst data", s_data, 0);
        check("rst wren", s_wren, 0);
        check("rst busy", s_busy, 0);
        check("rst finish", s_finish, 0);
        check("rst def busy", d_busy, 0);
        s_rst_n = 1'b1; d_rst_n = 1'b1;
        tick();

        // functional result, timing and i == j writes, key 0, N = 4
        run_small(8'h00, "small k00");
        check("k00 final vector", {s_mem[0], s_mem[1], s_mem[2], s_mem[3]}, 32'h00020301);
        check("i=j wr1 addr", s_wa_q[OFF_S], 0);
        check("i=j wr1 data", s_wd_q[OFF_S], 0);
        check("i=j wr2 addr", s_wa_q[OFF_S + 1], 0);
        check("i=j wr2 data", s_wd_q[OFF_S + 1], 0);
        check("i=2 wr_j addr", s_wa_q[OFF_S + 4], 3);
        check("i=2 wr_j data", s_wd_q[OFF_S + 4], 2);
        check("i=2 wr_i addr", s_wa_q[OFF_S + 5], 2);
        check("i=2 wr_i data", s_wd_q[OFF_S + 5], 3);

        // random keys on the small instance
        repeat (3) run_small(8'($urandom), "small rnd");

        // default configuration, reference key then a random key
        run_def(24'h000102, "def k000102");
        run_def(24'($urandom), "def rnd");

        // abort in WAIT_J of i = 5
        d_load = 1'b1; tick(); d_load = 1'b0;
        d_key = 24'($urandom); d_start = 1'b1;
        tick();
        d_start = 1'b0;
        repeat (OFF_D + 43) tick();
        check("abort at WAIT_J", d_dbg, 32'(S_WAIT_J));
        fc = d_fin_cnt;
        d_abort = 1'b1;
        tick();
        d_abort = 1'b0;
        check("abort busy", d_busy, 0);
        check("abort wren", d_wren, 0);
        check("abort finish", d_finish, 0);
        repeat (10) tick();
        check("abort no finish", d_fin_cnt - fc, 0);
        run_def(24'($urandom), "def after abort");

        // reset in WR_I of i = 1
        s_load = 1'b1; tick(); s_load = 1'b0;
        s_key = 8'($urandom); s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (OFF_S + 14) tick();
        check("mid-run at WR_I", s_dbg, 32'(S_WR_I));
        check("mid-run wren", s_wren, 1);
        check("mid-run addr i", s_addr, 1);
        fc = s_fin_cnt;
        s_rst_n = 1'b0;
        tick();
        check("midrst address", s_addr, 0);
        check("midrst data", s_data, 0);
        check("midrst wren", s_wren, 0);
        check("midrst busy", s_busy, 0);
        check("midrst finish", s_finish, 0);
        s_rst_n = 1'b1;
        repeat (5) tick();
        check("midrst no finish", s_fin_cnt - fc, 0);

        // start and abort together in IDLE
        s_start = 1'b1; s_abort = 1'b1;
        tick();
        s_start = 1'b0; s_abort = 1'b0;
        check("start+abort busy", s_busy, 0);
        check("start+abort state", s_dbg, 32'(S_IDLE));
        repeat (3) tick();
        check("start+abort later busy", s_busy, 0);
        check("start+abort wren", s_wren, 0);
        run_small(8'($urandom), "small after rst");

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/rc4_ksa_engine.md
RC4_KSA_ENGINE -- requirements
Module: rc4_ksa_engine

Interface
REQ-001 SHALL have parameter KEY_BYTES, default 3, secret key length in bytes (1..32).
REQ-002 SHALL have parameter ADDR_W, default 8, S-array address width; N = 2**ADDR_W entries.
REQ-003 SHALL have parameter DATA_W, default 8, S-array word width, with DATA_W >= ADDR_W.
REQ-004 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port start, input, 1, begin a run; sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1, cancel a run in progress.
REQ-008 SHALL have port secret_key, input, 8*KEY_BYTES, key; byte 0 is the most significant byte.
REQ-009 SHALL have port q, input, DATA_W, S-array read data.
REQ-010 SHALL have port address, output, ADDR_W, S-array address.
REQ-011 SHALL have port data, output, DATA_W, S-array write data.
REQ-012 SHALL have port wren, output, 1, S-array write enable.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port finish, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement the states IDLE, INIT, RD_I, WAIT_I, CAP_I, WAIT_J, CAP_J, WR_J, WR_I, NEXT and DONE.
REQ-016 SHALL capture secret_key into an internal register on the edge that accepts start; later key changes have no effect on the run.
REQ-017 SHALL treat S-array reads as two-cycle latency: q is valid in the second cycle after address is driven (RD_I→CAP_I, CAP_I→CAP_J).
REQ-018 SHALL, in CAP_I, latch si = q and set j = (j + si + key[i mod KEY_BYTES]) mod N, with operands truncated to ADDR_W bits, then drive address = j.
REQ-019 SHALL derive i mod KEY_BYTES from a wrapping key-index counter, not from a divider.
REQ-020 SHALL latch sj = q in CAP_J.
REQ-021 SHALL write (address=j, data=si, wren=1) in WR_J, then (address=i, data=sj, wren=1) in WR_I; wren SHALL be low in all other shuffle states.
REQ-022 SHALL, when i == j, perform both writes and leave the S-array entry unchanged.
REQ-023 SHALL, in NEXT, go to DONE if i == N-1; otherwise increment i and go to RD_I.
REQ-024 SHALL make each i iteration exactly 8 cycles (RD_I through NEXT), giving a shuffle phase of 8N cycles.
REQ-025 SHALL assert finish for exactly one cycle in DONE, then return to IDLE.
REQ-026 SHALL start each run with i = 0, j = 0 and key index = 0.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL, on abort in any non-IDLE state, go to IDLE on the next edge with wren = 0 and no finish pulse.
REQ-029 SHALL give abort priority over start when both are high in IDLE, and remain in IDLE.

Reset
REQ-030 SHALL, when reset_n is low at a clock edge, enter IDLE and clear address, data, wren, busy, finish, i, j, the key index and the latches to 0.
REQ-031 SHALL apply reset in any state, including mid-run; a run cut by reset produces no finish pulse.

Configuration
REQ-032 SHALL, with macro RC4_KSA_INIT_EN defined, go from start to INIT, write S[k] = k for k = 0..N-1 (one write per cycle, N cycles), then enter RD_I.
REQ-033 SHALL, without RC4_KSA_INIT_EN, go from start directly to RD_I, with the S-array pre-initialised externally; the INIT state is not present.

Structure
REQ-034 SHALL take the state enum typedef and the constant KEY_BYTE_W = 8 from shared package rc4_pkg.
REQ-035 SHALL use one sub-module, rc4_key_sel, which selects key byte [idx] from the captured key and owns the wrapping key-index counter.

Verification
REQ-036 SHALL verify functional result: ADDR_W=2, DATA_W=8, KEY_BYTES=1, key 8'h00, INIT_EN on, memory model → final S = [0,2,3,1].
REQ-037 SHALL verify timing: same configuration, start accepted at edge 0 → finish high in cycle 37 (N + 8N + 1) only; with INIT_EN off → cycle 33.
REQ-038 SHALL verify i == j handling: run with an iteration where i == j (e.g. i=0 with the REQ-036 setup) → two writes of the same value to that address, entry unchanged.
REQ-039 SHALL verify abort: abort pulsed in WAIT_J of i=5 → IDLE next edge, busy=0, wren=0, finish never asserted; a new start gives the correct full result.
REQ-040 SHALL verify reset mid-run: reset_n low in WR_I → all outputs 0 after the edge, no finish; start and abort high together in IDLE → stays IDLE.
REQ-041 SHALL verify the default configuration: ADDR_W=8, KEY_BYTES=3, key 24'h000102 → S-array matches the software RC4 KSA reference model; start pulses during busy are ignored.
